// File: rtl/i2c_target_responder_if.sv
// Host-side bundle of the I2C target: the raw SCL/SDA pins plus the RX pop and TX byte handshakes.
// The target drives the slave modport; the bus model or host drives the master modport.
interface i2c_target_responder_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        input  scl_in, sda_in, rx_ready, tx_data, tx_valid,
        output sda_oe, rx_data, rx_valid, tx_ready
    );

    modport master (
        output scl_in, sda_in, rx_ready, tx_data, tx_valid,
        input  sda_oe, rx_data, rx_valid, tx_ready
    );
endinterface

// File: rtl/i2c_target_responder.sv
// Generic FIFO. A pushed word is visible at the head on the next cycle.
// A push while full is dropped, judged before any same-cycle pop; a pop while empty is ignored.
module i2c_target_responder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             push_ok, pop_ok;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// I2C target: START/STOP detect, 7-bit address match with ACK, write bytes into the RX FIFO, and read bytes
// served from the TX handshake. Bus events lag the pins by SYNC_STAGES+1 cycles; no clock stretching.
module i2c_target_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int RX_DEPTH    = 4
) (
    input  logic                  clk_i2c,
    input  logic                  rst_i2c,
    i2c_target_responder_if.slave bus,
    input  logic                  enable,
    input  logic [6:0]            own_addr,
    output logic                  busy,
    output logic                  rw,
    output logic                  addr_hit,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  rx_overflow,
    output logic                  tx_underrun
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic                   rw_q, rw_d;
    logic                   phase_q, phase_d;
    logic                   ack_q, ack_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] rx_byte;
    logic       load_byte, push_c, rx_full, rx_empty;
    logic       hit_c, ovf_c, und_c, txr_c;

    // Idle bus is high, so the synchronizers reset to 1 to avoid phantom edges out of reset.
    always_ff @(posedge clk_i2c or posedge rst_i2c) begin
        if (rst_i2c) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s && !scl_hist_q;
    assign scl_fall = !scl_s && scl_hist_q;
    assign start_c  = scl_s && scl_hist_q && !sda_s && sda_hist_q;
    assign stop_c   = scl_s && scl_hist_q && sda_s && !sda_hist_q;
    assign rx_byte  = {shift_q[6:0], sda_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        ack_d     = ack_q;
        load_byte = 1'b0;
        push_c    = 1'b0;
        hit_c     = 1'b0;
        ovf_c     = 1'b0;
        und_c     = 1'b0;
        txr_c     = 1'b0;

        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (enable && rx_byte[7:1] == own_addr) begin
                            rw_d    = rx_byte[0];
                            hit_c   = 1'b1;
                            phase_d = 1'b0;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                // phase_q separates the fall that starts the ACK slot from the fall that ends it.
                ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else if (rw_q) begin
                        load_byte = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = WR_DATA;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push_c  = !rx_full;
                        ovf_c   = rx_full;
                        ack_d   = !rx_full;
                        phase_d = 1'b0;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = ack_q;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = WR_DATA;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = RD_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oe_d  = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) phase_d = 1'b1;
                        else        state_d = IGNORE;
                    end else if (scl_fall && phase_q) begin
                        load_byte = 1'b1;
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: state_d  = IDLE;
            endcase

            if (load_byte) begin
                txr_c     = bus.tx_valid;
                und_c     = !bus.tx_valid;
                shift_d   = bus.tx_valid ? bus.tx_data : 8'hFF;
                sda_oe_d  = bus.tx_valid ? ~bus.tx_data[7] : 1'b0;
                bit_cnt_d = 3'd0;
                state_d   = RD_DATA;
            end
        end
    end

    always_ff @(posedge clk_i2c or posedge rst_i2c) begin
        if (rst_i2c) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            ack_q     <= ack_d;
        end
    end

    i2c_target_responder_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i      (clk_i2c),
        .rst_i      (rst_i2c),
        .push_i     (push_c),
        .push_dat_i (rx_byte),
        .pop_i      (bus.rx_ready),
        .head_dat_o (bus.rx_data),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    assign bus.rx_valid = !rx_empty;
    assign bus.sda_oe   = sda_oe_q;
    assign bus.tx_ready = txr_c;
    assign busy         = busy_q;
    assign rw           = rw_q;
    assign addr_hit     = hit_c;
    assign start_det    = start_c;
    assign stop_det     = stop_c;
    assign rx_overflow  = ovf_c;
    assign tx_underrun  = und_c;
endmodule

// File: tb/tb_i2c_target_responder.sv
// Drives an I2C master bus model against the target; expected bytes/ACKs/pulse counts come from a
// transaction-level model and are compared by monitors as the target (or the bus) produces them.
module tb_i2c_target_responder;
    localparam int Q        = 5;
    localparam int RX_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_target_responder_if bus_if();

    logic       enable;
    logic [6:0] own_addr;
    logic       busy, rw, addr_hit, start_det, stop_det, rx_overflow, tx_underrun;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;

    assign bus_if.scl_in = scl_m;
    assign bus_if.sda_in = sda_m & ~bus_if.sda_oe;

    i2c_target_responder #(.SYNC_STAGES(2), .RX_DEPTH(RX_DEPTH)) dut (
        .clk_i2c     (clk),
        .rst_i2c     (rst),
        .bus         (bus_if),
        .enable      (enable),
        .own_addr    (own_addr),
        .busy        (busy),
        .rw          (rw),
        .addr_hit    (addr_hit),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .rx_overflow (rx_overflow),
        .tx_underrun (tx_underrun)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] obs_rd[$];
    logic [7:0] tx_src[$];
    int         exp_ack[$];
    int         obs_ack[$];
    logic [7:0] src_vals[4];

    int cnt_hit = 0, cnt_start = 0, cnt_stop = 0, cnt_txr = 0, cnt_und = 0, cnt_ovf = 0, oe_cycles = 0;
    int exp_hit = 0, exp_start = 0, exp_stop = 0, exp_txr = 0, exp_und = 0, exp_ovf = 0;
    int exp_rw = 0;
    int model_occ = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (addr_hit)       cnt_hit++;
            if (start_det)      cnt_start++;
            if (stop_det)       cnt_stop++;
            if (bus_if.tx_ready) cnt_txr++;
            if (tx_underrun)    cnt_und++;
            if (rx_overflow)    cnt_ovf++;
            if (bus_if.sda_oe)  oe_cycles++;
            if (bus_if.rx_valid && bus_if.rx_ready) begin
                if (exp_rx.size() == 0) unexp("rx_data", bus_if.rx_data);
                else                    chk("rx_data", bus_if.rx_data, exp_rx.pop_front());
            end
            if (obs_ack.size() > 0) begin
                if (exp_ack.size() == 0) unexp("ack", obs_ack.pop_front());
                else                     chk("ack", obs_ack.pop_front(), exp_ack.pop_front());
            end
            if (obs_rd.size() > 0) begin
                if (exp_rd.size() == 0) unexp("rd_byte", obs_rd.pop_front());
                else                    chk("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
            end
        end
    end

    // TX source: advance only after the cycle in which the target consumed the head byte.
    initial begin
        logic seen;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            seen = bus_if.tx_ready;
            @(posedge clk);
            #1;
            if (seen && tx_src.size() > 0) void'(tx_src.pop_front());
            bus_if.tx_valid = (tx_src.size() > 0);
            bus_if.tx_data  = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clock_bit(input logic d, output logic s);
        sda_m = d;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        s = bus_if.sda_in;
        wq(Q);
        scl_m = 1'b0;
        wq(Q);
    endtask

    task automatic do_start();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
        exp_start++;
    endtask

    task automatic do_rstart();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
        exp_start++;
    endtask

    task automatic do_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
        wq(Q);
        exp_stop++;
    endtask

    task automatic write_byte(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        obs_ack.push_back(s ? 0 : 1);
    endtask

    task automatic read_byte(input logic mack);
        logic       s;
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            r[i] = s;
        end
        clock_bit(!mack, s);
        obs_rd.push_back(r);
    endtask

    function automatic int write_ack_model();
        if (bus_if.rx_ready) return 1;
        if (model_occ < RX_DEPTH) begin
            model_occ++;
            return 1;
        end
        return 0;
    endfunction

    // One complete transaction: START, address, n data bytes, STOP. Reads serve src_vals[0..navail-1].
    task automatic txn(input logic [6:0] a, input logic rd, input int n, input int navail);
        logic       hit;
        logic [7:0] d;
        int         ok;
        hit = enable && (a == own_addr);
        if (rd) for (int k = 0; k < navail; k++) tx_src.push_back(src_vals[k]);
        do_start();
        chk("busy_after_start", busy, 1);
        exp_ack.push_back(hit ? 1 : 0);
        write_byte({a, rd});
        if (hit) begin
            exp_hit++;
            exp_rw = rd;
            for (int i = 0; i < n; i++) begin
                if (rd) begin
                    exp_rd.push_back(i < navail ? src_vals[i] : 8'hFF);
                    if (i < navail) exp_txr++;
                    else            exp_und++;
                    read_byte(i < n - 1);
                end else begin
                    d  = 8'($urandom_range(0, 255));
                    ok = write_ack_model();
                    exp_ack.push_back(ok);
                    if (ok != 0) exp_rx.push_back(d);
                    else         exp_ovf++;
                    write_byte(d);
                end
            end
        end
        do_stop();
        tx_src.delete();
        wq(4);
        chk("busy_after_stop", busy, 0);
        chk("sda_released", bus_if.sda_oe, 0);
        chk("rw", rw, exp_rw);
        chk("cnt_addr_hit", cnt_hit, exp_hit);
        chk("cnt_start", cnt_start, exp_start);
        chk("cnt_stop", cnt_stop, exp_stop);
        chk("cnt_tx_ready", cnt_txr, exp_txr);
        chk("cnt_tx_underrun", cnt_und, exp_und);
        chk("cnt_rx_overflow", cnt_ovf, exp_ovf);
    endtask

    initial begin
        int oe_snap;
        logic s;
        enable          = 1'b1;
        own_addr        = 7'h50;
        bus_if.rx_ready = 1'b1;
        wq(3);
        chk("rst_sda_oe", bus_if.sda_oe, 0);
        chk("rst_rx_valid", bus_if.rx_valid, 0);
        chk("rst_rx_data", bus_if.rx_data, 0);
        chk("rst_tx_ready", bus_if.tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rw", rw, 0);
        chk("rst_pulses", {addr_hit, start_det, stop_det, rx_overflow, tx_underrun}, 0);
        rst = 1'b0;
        wq(4);

        // write A0h,3Ch
        exp_start++;
        sda_m = 1'b0; wq(Q); scl_m = 1'b0; wq(Q);
        exp_ack.push_back(1); write_byte(8'hA0);
        exp_hit++; exp_rw = 0;
        exp_ack.push_back(1); exp_rx.push_back(8'h3C); write_byte(8'h3C);
        do_stop();
        wq(4);
        chk("t1_hit", cnt_hit, exp_hit);
        chk("t1_start_stop", {cnt_start[15:0], cnt_stop[15:0]}, {exp_start[15:0], exp_stop[15:0]});

        // foreign address: no ACK, SDA untouched
        oe_snap = oe_cycles;
        txn(7'h51, 1'b0, 0, 0);
        chk("t2_sda_quiet", oe_cycles - oe_snap, 0);
        chk("t2_rx_valid", bus_if.rx_valid, 0);

        // read 5Ah, then read with empty source
        src_vals[0] = 8'h5A;
        txn(7'h50, 1'b1, 1, 1);
        txn(7'h50, 1'b1, 1, 0);

        // overflow: five writes into a four-deep FIFO with no pops
        bus_if.rx_ready = 1'b0;
        model_occ       = 0;
        txn(7'h50, 1'b0, 5, 0);
        chk("t5_rx_valid_held", bus_if.rx_valid, 1);
        bus_if.rx_ready = 1'b1;
        for (int i = 0; i < 50 && exp_rx.size() > 0; i++) wq(1);
        chk("t5_drained", exp_rx.size(), 0);
        model_occ = 0;

        // enable low: matching address is NACKed
        enable = 1'b0;
        txn(7'h50, 1'b0, 1, 0);
        enable = 1'b1;

        for (int t = 0; t < 20; t++) begin
            logic [6:0] a;
            enable   = ($urandom_range(0, 3) != 0);
            own_addr = 7'($urandom_range(0, 127));
            a        = ($urandom_range(0, 1) != 0) ? own_addr : 7'($urandom_range(0, 127));
            for (int k = 0; k < 4; k++) src_vals[k] = 8'($urandom_range(0, 255));
            txn(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(0, 3));
        end

        // write, repeated START into a read, then reset in the middle of a driven byte
        enable   = 1'b1;
        own_addr = 7'h50;
        src_vals[0] = 8'h00;
        src_vals[1] = 8'h00;
        tx_src.push_back(8'h00);
        tx_src.push_back(8'h00);
        do_start();
        exp_ack.push_back(1); write_byte(8'hA0);
        exp_ack.push_back(1); exp_rx.push_back(8'h11); write_byte(8'h11);
        do_rstart();
        exp_ack.push_back(1); write_byte(8'hA1);
        exp_hit += 2;
        exp_rd.push_back(8'h00); read_byte(1'b1);
        exp_txr += 2;
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        scl_m = 1'b1;
        wq(2);
        chk("t6_drive_low", bus_if.sda_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_sda_oe", bus_if.sda_oe, 0);
        chk("t6_rst_outputs", {busy, rw, bus_if.rx_valid, bus_if.tx_ready, addr_hit, start_det,
                               stop_det, rx_overflow, tx_underrun}, 0);
        chk("t6_cnt_start", cnt_start, exp_start);
        chk("t6_cnt_tx_ready", cnt_txr, exp_txr);
        sda_m = 1'b1;
        scl_m = 1'b1;
        tx_src.delete();
        wq(3);
        rst = 1'b0;
        wq(10);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_rx_valid", bus_if.rx_valid, 0);

        wq(5);
        chk("left_exp_rx", exp_rx.size(), 0);
        chk("left_exp_ack", exp_ack.size(), 0);
        chk("left_exp_rd", exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
